vga_fb_arbiter: RTL and testbench

Arbitrates a single-port synchronous frame-buffer RAM between the display fetch path and a posted pixel writer. The display side is driven by the VGA position/visible outputs of the timing block and has absolute priority: every visible pixel issues exactly one read, never stalled. Writes enter a small FIFO with a valid/ready handshake and drain into the RAM only in cycles with no display read (blanking or porch). It sits between the VGA timing block, the frame-buffer RAM and the pixel source (capture path or drawing engine).

---
 rtl/vga_fb_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port synchronous frame-buffer RAM between the display
// fetch path and a posted pixel writer. Display reads own every visible
// cycle and are never stalled. Writes are buffered in a small FIFO and
// drained in blanking/porch cycles, in arrival order.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   display_row, visible    raster position from the VGA timing block
//   wr_valid/wr_ready       posted write handshake (wr_addr, wr_data)
//   ram_addr/ram_we/ram_wdata  registered RAM command, one access per cycle
//   ram_rdata               RAM read data, one cycle after the address
//   pix_data/pix_valid      fetched pixel to the DAC (0 when not valid)
//   fifo_level              entries currently buffered
//   err_addr                sticky: an out-of-range write was discarded
module vga_fb_arbiter #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [10:0]       display_row,
  input  logic              visible,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              err_addr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned TOTAL = H_VISIBLE * V_VISIBLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_e;

  wr_entry_t         fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              wr_ready_q, wr_ready_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              iss1_q, iss1_d;
  logic              iss2_q, iss2_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              err_addr_q, err_addr_d;

  logic              push_c;
  logic              pop_c;
  logic              head_ok_c;
  wr_entry_t         head_c;
  slot_e             slot_c;

  // Slot decision: display reads win; writes only drain when not visible.
  always_comb begin
    push_c    = wr_valid && wr_ready_q;
    head_c    = fifo_mem_q[rd_ptr_q];
    head_ok_c = (32'(head_c.addr) < TOTAL);
    if (visible) begin
      slot_c = SLOT_READ;
    end else if (level_q != '0) begin
      slot_c = SLOT_WRITE;
    end else begin
      slot_c = SLOT_IDLE;
    end
    pop_c = (slot_c == SLOT_WRITE);
  end

  // Next-state logic for counters, FIFO bookkeeping, RAM command and pixel pipe.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wr_ready_d  = wr_ready_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    err_addr_d  = err_addr_q;
    iss1_d      = 1'b0;
    iss2_d      = iss1_q;
    pix_data_d  = '0;
    pix_valid_d = 1'b0;

    // Row 0 re-anchors the fetch address at the top of the frame.
    if (display_row == 11'd0) begin
      rd_addr_d = '0;
    end else if (visible) begin
      rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
    end

    unique case (slot_c)
      SLOT_READ: begin
        ram_addr_d = rd_addr_q;
        iss1_d     = 1'b1;
      end
      SLOT_WRITE: begin
        if (head_ok_c) begin
          ram_addr_d  = head_c.addr;
          ram_wdata_d = head_c.data;
          ram_we_d    = 1'b1;
        end else begin
          err_addr_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d    = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    wr_ready_d = (level_d < LVL_W'(FIFO_DEPTH));

    // Issue flag from two cycles back marks ram_rdata as a display fetch.
    if (iss2_q) begin
      pix_data_d  = ram_rdata;
      pix_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wr_ready_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      iss1_q      <= 1'b0;
      iss2_q      <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      err_addr_q  <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wr_ready_q  <= wr_ready_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      iss1_q      <= iss1_d;
      iss2_q      <= iss2_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // FIFO storage needs no reset; pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push_c) begin
      fifo_mem_q[wr_ptr_q] <= wr_entry_t'{addr: wr_addr, data: wr_data};
    end
  end

  assign wr_ready   = wr_ready_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign fifo_level = level_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a full-size instance for display,
// write and error behaviour, and a small-frame instance for address wrap.
module tb_vga_fb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // Full-size instance
  logic [10:0] display_row = 11'd0;
  logic        visible = 1'b0;
  logic        wr_valid = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata = '0;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic [2:0]  fifo_level;
  logic        err_addr;

  // Small-frame instance (8x4 = 32 pixels)
  logic [10:0] s_row = 11'd1;
  logic        s_visible = 1'b0;
  logic        s_wr_valid = 1'b0;
  logic [5:0]  s_wr_addr = '0;
  logic [11:0] s_wr_data = '0;
  logic        s_wr_ready;
  logic [5:0]  s_ram_addr;
  logic        s_ram_we;
  logic [11:0] s_ram_wdata;
  logic [11:0] s_ram_rdata = '0;
  logic [11:0] s_pix_data;
  logic        s_pix_valid;
  logic [2:0]  s_fifo_level;
  logic        s_err_addr;

  int vectors = 0;
  int errors  = 0;

  vga_fb_arbiter dut (
    .clock(clock), .reset(reset), .display_row(display_row), .visible(visible),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .fifo_level(fifo_level),
    .err_addr(err_addr)
  );

  vga_fb_arbiter #(.H_VISIBLE(8), .V_VISIBLE(4), .ADDR_W(6)) dut_small (
    .clock(clock), .reset(reset), .display_row(s_row), .visible(s_visible),
    .wr_valid(s_wr_valid), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .wr_ready(s_wr_ready), .ram_addr(s_ram_addr), .ram_we(s_ram_we),
    .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata), .pix_data(s_pix_data),
    .pix_valid(s_pix_valid), .fifo_level(s_fifo_level), .err_addr(s_err_addr)
  );

  always #5 clock = ~clock;

  // RAM model: returns the low bits of the address one cycle later.
  always @(posedge clock) begin
    ram_rdata <= 12'(ram_addr);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held 3 cycles with a pending write request
    wr_valid = 1'b1;
    wr_addr  = 19'd7;
    wr_data  = 12'h777;
    repeat (3) tick();
    chk("rst_ram_addr",  32'(ram_addr), 0);
    chk("rst_ram_we",    32'(ram_we), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_pix_data",  32'(pix_data), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_level",     32'(fifo_level), 0);
    chk("rst_wr_ready",  32'(wr_ready), 0);
    chk("rst_err_addr",  32'(err_addr), 0);
    reset = 1'b0;
    tick();
    chk("rel_wr_ready", 32'(wr_ready), 1);
    chk("rel_no_push",  32'(fifo_level), 0);
    wr_valid = 1'b0;

    // Display stream: one visible line of 800 pixels
    display_row = 11'd1;
    for (int c = 0; c < 810; c++) begin
      visible = (c < 800);
      tick();
      if (c >= 2 && c <= 801) begin
        chk("disp_valid", 32'(pix_valid), 1);
        chk("disp_data",  32'(pix_data), 32'(c - 2));
      end else begin
        chk("disp_valid_off", 32'(pix_valid), 0);
        chk("disp_data_off",  32'(pix_data), 0);
      end
      chk("disp_no_we", 32'(ram_we), 0);
    end

    // Posted writes while visible fill the FIFO
    visible = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 19'(10 + i);
      wr_data  = 12'(12'hA00 + i);
      tick();
      chk("fill_level", 32'(fifo_level), 32'(i + 1));
      chk("fill_ready", 32'(wr_ready), (i < 3) ? 1 : 0);
      chk("fill_no_we", 32'(ram_we), 0);
    end
    // First blanking cycle: full FIFO refuses the new request, pops the head
    visible = 1'b0;
    wr_addr = 19'd99;
    wr_data = 12'h099;
    tick();
    wr_valid = 1'b0;
    chk("drain0_we",    32'(ram_we), 1);
    chk("drain0_addr",  32'(ram_addr), 10);
    chk("drain0_data",  32'(ram_wdata), 32'h0A00);
    chk("drain0_level", 32'(fifo_level), 3);
    chk("drain0_ready", 32'(wr_ready), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_we",    32'(ram_we), 1);
      chk("drain_addr",  32'(ram_addr), 32'(10 + i));
      chk("drain_data",  32'(ram_wdata), 32'(12'hA00 + i));
      chk("drain_level", 32'(fifo_level), 32'(3 - i));
    end
    tick();
    chk("idle_we",    32'(ram_we), 0);
    chk("idle_addr",  32'(ram_addr), 13);
    chk("idle_data",  32'(ram_wdata), 32'h0A03);
    chk("idle_level", 32'(fifo_level), 0);
    chk("idle_ready", 32'(wr_ready), 1);

    // Out-of-range write is discarded and latches err_addr
    wr_valid = 1'b1;
    wr_addr  = 19'd480000;
    wr_data  = 12'hBAD;
    tick();
    chk("bad_push_level", 32'(fifo_level), 1);
    chk("bad_push_we",    32'(ram_we), 0);
    chk("bad_push_err",   32'(err_addr), 0);
    wr_addr = 19'd5;
    wr_data = 12'h555;
    tick();
    chk("bad_pop_we",    32'(ram_we), 0);
    chk("bad_pop_err",   32'(err_addr), 1);
    chk("bad_pop_level", 32'(fifo_level), 1);
    wr_valid = 1'b0;
    tick();
    chk("good_we",    32'(ram_we), 1);
    chk("good_addr",  32'(ram_addr), 5);
    chk("good_data",  32'(ram_wdata), 32'h0555);
    chk("good_level", 32'(fifo_level), 0);
    tick();
    chk("err_sticky", 32'(err_addr), 1);
    chk("err_idle_we", 32'(ram_we), 0);

    // Simultaneous push and pop at level 2 during blanking
    visible  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 19'd30; wr_data = 12'h301;
    tick();
    wr_addr  = 19'd31; wr_data = 12'h302;
    tick();
    chk("pp_pre_level", 32'(fifo_level), 2);
    visible = 1'b0;
    wr_addr = 19'd32; wr_data = 12'h303;
    tick();
    chk("pp0_level", 32'(fifo_level), 2);
    chk("pp0_addr",  32'(ram_addr), 30);
    chk("pp0_data",  32'(ram_wdata), 32'h0301);
    wr_addr = 19'd33; wr_data = 12'h304;
    tick();
    chk("pp1_level", 32'(fifo_level), 2);
    chk("pp1_addr",  32'(ram_addr), 31);
    chk("pp1_data",  32'(ram_wdata), 32'h0302);
    wr_valid = 1'b0;
    tick();
    chk("pp2_addr",  32'(ram_addr), 32);
    chk("pp2_level", 32'(fifo_level), 1);
    tick();
    chk("pp3_addr",  32'(ram_addr), 33);
    chk("pp3_data",  32'(ram_wdata), 32'h0304);
    chk("pp3_we",    32'(ram_we), 1);
    chk("pp3_level", 32'(fifo_level), 0);

    // Frame wrap on the 32-pixel instance: reads 0..31 then 0,1
    s_row = 11'd1;
    s_visible = 1'b1;
    for (int k = 0; k < 34; k++) begin
      tick();
      chk("wrap_addr", 32'(s_ram_addr), 32'(k % 32));
      chk("wrap_we",   32'(s_ram_we), 0);
    end
    // Row 0 mid-line re-anchors the fetch address
    s_visible = 1'b0;
    s_row = 11'd0;
    tick();
    s_row = 11'd1;
    s_visible = 1'b1;
    tick();
    chk("row0_addr", 32'(s_ram_addr), 0);
    tick();
    chk("row0_next", 32'(s_ram_addr), 1);
    s_visible = 1'b0;

    // Reset mid-operation drops buffered writes and in-flight reads
    visible  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 19'd20; wr_data = 12'h020;
    tick();
    wr_addr  = 19'd21; wr_data = 12'h021;
    tick();
    wr_valid = 1'b0;
    visible  = 1'b0;
    reset    = 1'b1;
    tick();
    chk("mrst_we",    32'(ram_we), 0);
    chk("mrst_level", 32'(fifo_level), 0);
    chk("mrst_ready", 32'(wr_ready), 0);
    chk("mrst_pixv",  32'(pix_valid), 0);
    chk("mrst_err",   32'(err_addr), 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_we",   32'(ram_we), 0);
      chk("post_pixv", 32'(pix_valid), 0);
      chk("post_level", 32'(fifo_level), 0);
    end
    chk("post_ready", 32'(wr_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
